// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the ctrl_seq instruction sequencer: FSM state
// encoding, instruction-type codes, the halt opcode and a one-hot helper.
package ctrl_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    // Instruction types reported by the decoder on dec_type.
    // Type 0 is a jump; all other types advance pc by one.
    localparam logic [1:0] TYPE_JUMP = 2'b00;
    localparam logic [1:0] TYPE_OP1  = 2'b01;
    localparam logic [1:0] TYPE_OP2  = 2'b10;
    localparam logic [1:0] TYPE_OP3  = 2'b11;

    // Fetched instruction that stops the sequencer instead of executing.
    localparam logic [7:0] HALT_OPCODE = 8'hFF;

    // One-hot execute strobe for an instruction type.
    function automatic logic [3:0] type_onehot(input logic [1:0] t);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[t] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/ex_watchdog.sv
// Execute-phase watchdog. The count is cleared as the sequencer enters
// EXEC and advances once per EXEC cycle without ex_done. 'expired' fires
// combinationally on the tick that would bring the count to LIMIT, so the
// sequencer can leave EXEC on exactly the LIMIT-th idle cycle; a cycle
// that carries ex_done never ticks, so completion always wins.
module ex_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(LIMIT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = tick && !clear && (cnt_q == LAST_IDLE);

    // Next count: clear wins, otherwise count idle EXEC cycles up to LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Fetch / decode / execute sequencer. Fetches an 8-bit instruction at pc,
// hands it to an external decoder, strobes the matching execute unit and
// advances pc (or jumps) when that unit reports done. An all-ones opcode or
// an execute timeout parks the block in HALT until reset.
//
// Handshakes: imem_req holds with a stable imem_addr until a cycle with
// imem_ack, whose imem_data is captured on that same edge. dec_en holds for
// the whole DECODE state; dec_ready is only honoured from its second cycle,
// giving the decoder one cycle to see the new dec_inst. ex_go is a one-cycle
// strobe on the first EXEC cycle; ex_done is accepted on any EXEC cycle,
// including that first one. Acks/dones outside their state are ignored.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int EX_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic            dec_en,
    output logic [7:0]      dec_inst,
    input  logic            dec_ready,
    input  logic [1:0]      dec_type,
    input  logic [5:0]      dec_addr,
    output logic [3:0]      ex_go,
    input  logic            ex_done,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      inst_q, inst_d;
    logic [1:0]      type_q, type_d;
    logic [5:0]      addr_q, addr_d;
    logic            dec_seen_q, dec_seen_d;
    logic [3:0]      ex_go_q, ex_go_d;
    logic            err_q, err_d;

    logic            wd_clear;
    logic            wd_tick;
    logic            wd_expired;

    ex_watchdog #(
        .LIMIT (EX_TIMEOUT)
    ) u_ex_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    // Next-state logic: state transitions, instruction capture and pc update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        type_d     = type_q;
        addr_d     = addr_q;
        dec_seen_d = 1'b0;
        ex_go_d    = 4'b0000;
        err_d      = err_q;
        wd_clear   = 1'b0;
        wd_tick    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (imem_ack) begin
                    inst_d  = imem_data;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                // Marks that the first DECODE cycle has passed.
                dec_seen_d = 1'b1;
                if (dec_seen_q && dec_ready) begin
                    if (inst_q == HALT_OPCODE) begin
                        state_d = ST_HALT;
                    end else begin
                        // Decoder fields are captured here so EXEC does not
                        // depend on the decoder holding them.
                        type_d   = dec_type;
                        addr_d   = dec_addr;
                        ex_go_d  = type_onehot(dec_type);
                        wd_clear = 1'b1;
                        state_d  = ST_EXEC;
                    end
                end
            end

            ST_EXEC: begin
                if (ex_done) begin
                    if (type_q == TYPE_JUMP) begin
                        pc_d = PC_W'(addr_q);
                    end else begin
                        // Natural wrap at 2^PC_W, no flag.
                        pc_d = pc_q + PC_W'(1);
                    end
                    state_d = ST_FETCH;
                end else begin
                    wd_tick = 1'b1;
                    if (wd_expired) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops everything to IDLE / zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            inst_q     <= 8'h00;
            type_q     <= 2'b00;
            addr_q     <= 6'h00;
            dec_seen_q <= 1'b0;
            ex_go_q    <= 4'b0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            dec_seen_q <= dec_seen_d;
            ex_go_q    <= ex_go_d;
            err_q      <= err_d;
        end
    end

    // Request outputs decode directly from the state register, so reset
    // (state IDLE) and HALT both hold them at zero.
    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign dec_en    = (state_q == ST_DECODE);
    assign dec_inst  = inst_q;
    assign ex_go     = ex_go_q;
    assign pc        = pc_q;
    assign halted    = (state_q == ST_HALT);
    assign err       = err_q;

endmodule

// File: doc/ctrl_seq.md
CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have parameter PC_W, default 8: program counter and instruction-memory address width.
REQ-002 SHALL have parameter EX_TIMEOUT, default 255: maximum cycles to wait for ex_done.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start request; sampled in IDLE.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_ack  in  1  fetch complete; imem_data valid this cycle.
- imem_data  in  8  fetched instruction.
- dec_en  out  1  decoder enable.
- dec_inst  out  8  latched instruction to the decoder.
- dec_ready  in  1  decoder outputs valid.
- dec_type  in  2  decoded instruction type.
- dec_addr  in  6  decoded address field.
- ex_go  out  4  one-hot execute strobe, bit n for type n.
- ex_done  in  1  execute unit finished.
- pc  out  PC_W  program counter.
- halted  out  1  sequencer stopped.
- err  out  1  execute timeout occurred.

Function
REQ-004 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, HALT.
REQ-005 IDLE: run=1 -> FETCH next cycle; otherwise stay in IDLE.
REQ-006 FETCH: imem_req=1 and imem_addr=pc every cycle until imem_ack; on imem_ack, latch imem_data into dec_inst, deassert imem_req next cycle, go to DECODE.
REQ-007 DECODE: dec_en=1 for the whole state; dec_ready SHALL be ignored in the first DECODE cycle; from the second cycle on, dec_ready=1 -> EXEC.
REQ-008 EXEC entry: ex_go[dec_type]=1 for exactly one cycle, all other bits 0; dec_en SHALL be 0 in EXEC.
REQ-009 EXEC: wait for ex_done. On ex_done: type 2'b00 sets pc to dec_addr zero-extended to PC_W; every other type increments pc by 1 modulo 2^PC_W. In both cases -> FETCH.
REQ-010 Halt: dec_inst == 8'hFF at DECODE completion -> HALT; no ex_go pulse; pc unchanged.
REQ-011 Timeout: cycle counter cleared on EXEC entry, incremented each EXEC cycle without ex_done; reaching EXEC_TIMEOUT -> err=1, go to HALT, pc unchanged.
REQ-012 ex_done on the same cycle the counter reaches EXEC_TIMEOUT SHALL count as completion, not a timeout.
REQ-013 HALT: halted=1; every request output 0; exit only by reset.
REQ-014 pc wraps from 2^PC_W-1 to 0 without any flag.
REQ-015 imem_ack outside FETCH, and ex_done outside EXEC, SHALL be ignored.
REQ-016 run deasserting after IDLE SHALL have no effect.

Reset
REQ-017 rst_n=0 SHALL immediately force: IDLE, pc=0, dec_inst=0, timeout counter=0, and every output 0.
REQ-018 Reset mid-FETCH, mid-DECODE or mid-EXEC SHALL abandon the operation with no further strobes; after release the block starts from IDLE.

Structure
REQ-019 A shared package SHALL hold the state enum, the instruction-type encodings (2'b00..2'b11) and the HALT_OPCODE constant 8'hFF.
REQ-020 The timeout counter SHALL be a sub-module named ex_watchdog, with ports clk, rst_n, clear, tick and expired.

Verification
REQ-021 Basic fetch: reset, run=1, memory returns 8'h45 with imem_ack after 2 wait cycles -> dec_inst=8'h45; dec_en high for at least 2 cycles; ex_go=4'b0010 pulse; after ex_done, pc=1.
REQ-022 Jump: instruction 8'h2A, ex_done -> pc=8'h2A; next imem_addr=8'h2A.
REQ-023 Halt: instruction 8'hFF -> halted=1; ex_go never pulses; pc holds.
REQ-024 Timeout: ex_done held low -> err=1 and halted=1 after exactly 255 EXEC cycles; with ex_done on cycle 255, no err and pc increments.
REQ-025 Wrap: pc=8'hFF, non-jump instruction completes -> pc=8'h00.
REQ-026 Reset mid-EXEC: rst_n low while in EXEC -> all outputs 0 immediately; after release, no ex_go until run=1.
